// File: rtl/gpio_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_ctrl
// Bus-side GPIO register file and edge-triggered interrupt controller for the
// sysio peripheral group. Drives output value and output enable into the pad
// mux, synchronises the raw pin levels coming back, detects rising/falling
// edges on the low INT_NUM pins and raises a level interrupt while any
// pending flag is set.
//
// Register map (byte offset, decoded on address bits [4:0]):
//   0x00 DIN  RO   synchronised gpio_in
//   0x04 OPT  RW   output value, drives gpio_out
//   0x08 OEC  RW   output enable, drives gpio_oe
//   0x0C TAI  RW   per-pin {edge select, enable}; bit 2x enable, 2x+1 rising
//   0x10 IPD  W1C  pending interrupt flags [INT_NUM-1:0]
//   Any other offset: writes ignored, reads return 0.
//
// Parameters:
//   SYNC_STAGES  flops in the gpio_in synchroniser chain (>= 2)
//   INT_NUM      number of interrupt-capable pins, GPIO0 upwards (1..16)
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   waddr_i   write byte offset
//   data_i    write data
//   sel_i     write byte enables, sel_i[n] covers data_i[8n+7:8n]
//   we_i      write strobe, one cycle per write
//   raddr_i   read byte offset
//   rd_i      read strobe
//   data_o    registered read data, holds when rd_i is low
//   gpio_oe   per-pin output enable
//   gpio_out  per-pin output value
//   gpio_in   raw asynchronous pin levels
//   irq_o     level interrupt request, OR of the pending flags
// ---------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int INT_NUM     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic [31:0] gpio_oe,
  output logic [31:0] gpio_out,
  input  logic [31:0] gpio_in,
  output logic        irq_o
);

  // Mask with the low n bits set; used to keep TAI bits above the
  // interrupt-capable range permanently zero.
  function automatic logic [31:0] lowMask(input int n);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  localparam logic [4:0]  ADDR_DIN = 5'h00;
  localparam logic [4:0]  ADDR_OPT = 5'h04;
  localparam logic [4:0]  ADDR_OEC = 5'h08;
  localparam logic [4:0]  ADDR_TAI = 5'h0C;
  localparam logic [4:0]  ADDR_IPD = 5'h10;
  localparam logic [31:0] TAI_MASK = lowMask(2 * INT_NUM);

  // Only address bits [4:0] take part in decoding; the upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i[7:5], raddr_i[7:5]};

  logic [31:0]        opt_q, opt_d;
  logic [31:0]        oec_q, oec_d;
  logic [31:0]        tai_q, tai_d;
  logic [INT_NUM-1:0] ipd_q, ipd_d;
  logic [31:0]        data_q, data_d;
  logic               irq_q, irq_d;
  logic [31:0]        sync_q [SYNC_STAGES];
  logic [INT_NUM-1:0] din_q;

  logic [31:0]        byteMask;
  logic               wrOpt, wrOec, wrTai, wrIpd;
  logic [31:0]        din;
  logic [INT_NUM-1:0] rise, fall, ipdSet, ipdClr;
  logic [31:0]        rdData;

  // Expand the byte enables into a bit mask for the masked register writes.
  always_comb begin
    byteMask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  end

  // Write decode.
  always_comb begin
    wrOpt = we_i && (waddr_i[4:0] == ADDR_OPT);
    wrOec = we_i && (waddr_i[4:0] == ADDR_OEC);
    wrTai = we_i && (waddr_i[4:0] == ADDR_TAI);
    wrIpd = we_i && (waddr_i[4:0] == ADDR_IPD);
  end

  // Byte-masked next state for the plain read/write registers. With all
  // byte enables low the mask is zero and the registers keep their value.
  always_comb begin
    opt_d = opt_q;
    oec_d = oec_q;
    tai_d = tai_q;
    if (wrOpt) begin
      opt_d = (opt_q & ~byteMask) | (data_i & byteMask);
    end
    if (wrOec) begin
      oec_d = (oec_q & ~byteMask) | (data_i & byteMask);
    end
    if (wrTai) begin
      tai_d = ((tai_q & ~byteMask) | (data_i & byteMask)) & TAI_MASK;
    end
  end

  // Pin synchroniser: the last stage is DIN. Reset clears the chain so that
  // a pin held high across reset produces one fresh rising edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign din = sync_q[SYNC_STAGES-1];

  // One more flop on the interrupt-capable pins gives the previous level
  // for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
    end else begin
      din_q <= din[INT_NUM-1:0];
    end
  end

  // Edge detection uses the current TAI contents, so a TAI write landing on
  // the same edge only affects detection from the following cycle.
  always_comb begin
    rise   = din[INT_NUM-1:0] & ~din_q;
    fall   = ~din[INT_NUM-1:0] & din_q;
    ipdSet = '0;
    for (int x = 0; x < INT_NUM; x++) begin
      ipdSet[x] = tai_q[2*x] & (tai_q[2*x+1] ? rise[x] : fall[x]);
    end
  end

  // Pending flags: write-one-to-clear, with a simultaneous set taking
  // priority over the clear so no edge is ever lost.
  always_comb begin
    ipdClr = '0;
    if (wrIpd) begin
      ipdClr = data_i[INT_NUM-1:0] & byteMask[INT_NUM-1:0];
    end
    ipd_d = (ipd_q & ~ipdClr) | ipdSet;
    irq_d = |ipd_d;
  end

  // Read mux works on the current register values, so a read and a write to
  // the same register in one cycle return the old contents.
  always_comb begin
    rdData = '0;
    case (raddr_i[4:0])
      ADDR_DIN: rdData = din;
      ADDR_OPT: rdData = opt_q;
      ADDR_OEC: rdData = oec_q;
      ADDR_TAI: rdData = tai_q;
      ADDR_IPD: rdData[INT_NUM-1:0] = ipd_q;
      default:  rdData = '0;
    endcase
    data_d = rd_i ? rdData : data_q;
  end

  // Register file, read data and interrupt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_q  <= '0;
      oec_q  <= '0;
      tai_q  <= '0;
      ipd_q  <= '0;
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      opt_q  <= opt_d;
      oec_q  <= oec_d;
      tai_q  <= tai_d;
      ipd_q  <= ipd_d;
      data_q <= data_d;
      irq_q  <= irq_d;
    end
  end

  assign data_o   = data_q;
  assign gpio_out = opt_q;
  assign gpio_oe  = oec_q;
  assign irq_o    = irq_q;

endmodule
